delta_rle_enc_mc: RTL and testbench

Multi-channel delta/run-length encoder for the display-controller compression path; successor to the single-channel delta/RLE encoder. It accepts packed CH-channel pixels under valid/ready and compares each pixel with the previous one. Output is a serialized stream of fixed-width tokens: run, packed-delta, per-channel literal and end-of-line. The block supports full output backpressure, run saturation and per-line predictor reset, and feeds the link packetizer ahead of the display link.

---
 rtl/delta_rle_enc_mc.sv | 153 +++++++++++++++
 tb/tb_delta_rle_enc_mc.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/delta_rle_enc_mc.sv
// Multi-channel delta/run-length encoder: packed CH-channel pixels in,
// serialized fixed-width run / packed-delta / literal / EOL tokens out.
module delta_rle_enc_mc #(
    parameter int PIXW   = 10,
    parameter int CH     = 3,
    parameter int BUSW   = 16,
    parameter int DW     = 4,
    parameter int MAXRUN = 2**(BUSW-2)-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [CH*PIXW-1:0]   px_in,
    input  logic                 eol_in,
    output logic                 ready_in,
    output logic                 valid_out,
    output logic [BUSW-1:0]      data_out,
    input  logic                 ready_out
);
    localparam int RW   = BUSW - 2;
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int DMIN = -(2**(DW-1));
    localparam int DMAX = 2**(DW-1) - 1;

    typedef enum logic [1:0] {IDLE, PIX, LIT, EOL} state_t;

    state_t               state;
    logic [CH*PIXW-1:0]   prev;
    logic [CH*PIXW-1:0]   pend_px;
    logic                 pend_eol;
    logic [RW-1:0]        run;
    logic [CW-1:0]        lit_cnt;

    logic                 slot_free;
    logic [CH*PIXW-1:0]   src_px;
    logic                 src_eol;
    logic                 match;
    logic                 delta_ok;
    logic [BUSW-1:0]      first_tok;
    logic [BUSW-1:0]      lit_tok;
    logic [RW-1:0]        run_inc;
    logic [PIXW-1:0]      cur_ch;
    logic [PIXW-1:0]      old_ch;
    logic signed [PIXW:0] d;

    assign slot_free = !valid_out || ready_out;
    assign ready_in  = !rst && (state == IDLE) && slot_free;
    assign run_inc   = run + 1'b1;

    // In IDLE the incoming pixel is examined directly; afterwards the latched copy.
    always_comb begin
        src_px    = (state == IDLE) ? px_in : pend_px;
        src_eol   = (state == IDLE) ? eol_in : pend_eol;
        match     = (src_px == prev);
        delta_ok  = 1'b1;
        first_tok = '0;
        cur_ch    = '0;
        old_ch    = '0;
        d         = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            cur_ch = src_px[(CH-1-c)*PIXW +: PIXW];
            old_ch = prev[(CH-1-c)*PIXW +: PIXW];
            d      = $signed({1'b0, cur_ch}) - $signed({1'b0, old_ch});
            if (d < DMIN || d > DMAX)
                delta_ok = 1'b0;
            first_tok[(CH-1-c)*DW +: DW] = d[DW-1:0];
        end
        if (!delta_ok) begin
            first_tok                 = '0;
            first_tok[BUSW-1 -: 2]    = 2'b01;
            first_tok[PIXW-1:0]       = src_px[CH*PIXW-1 -: PIXW];
        end
        lit_tok              = '0;
        lit_tok[BUSW-1 -: 2] = 2'b01;
        lit_tok[PIXW-1:0]    = pend_px[(CH-1-int'(lit_cnt))*PIXW +: PIXW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            pend_px   <= '0;
            pend_eol  <= 1'b0;
            run       <= '0;
            lit_cnt   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (slot_free) begin
            valid_out <= 1'b0;
            // IDLE without a run/EOL need, or PIX: emit delta or first literal.
            if ((state == PIX) || (state == IDLE && valid_in && !match && run == '0)) begin
                valid_out <= 1'b1;
                data_out  <= first_tok;
                prev      <= src_px;
                pend_px   <= src_px;
                pend_eol  <= src_eol;
                if (delta_ok || CH == 1) begin
                    lit_cnt <= '0;
                    state   <= src_eol ? EOL : IDLE;
                end else begin
                    lit_cnt <= CW'(1);
                    state   <= LIT;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (valid_in) begin
                            pend_px  <= px_in;
                            pend_eol <= eol_in;
                            if (match) begin
                                if (eol_in) begin
                                    valid_out <= 1'b1;
                                    data_out  <= {2'b10, run_inc};
                                    run       <= '0;
                                    state     <= EOL;
                                end else if (run_inc == RW'(MAXRUN)) begin
                                    valid_out <= 1'b1;
                                    data_out  <= {2'b10, run_inc};
                                    run       <= '0;
                                end else begin
                                    run <= run_inc;
                                end
                            end else begin
                                valid_out <= 1'b1;
                                data_out  <= {2'b10, run};
                                run       <= '0;
                                state     <= PIX;
                            end
                        end
                    end
                    LIT: begin
                        valid_out <= 1'b1;
                        data_out  <= lit_tok;
                        if (lit_cnt == CW'(CH-1)) begin
                            lit_cnt <= '0;
                            state   <= pend_eol ? EOL : IDLE;
                        end else begin
                            lit_cnt <= lit_cnt + 1'b1;
                        end
                    end
                    EOL: begin
                        valid_out <= 1'b1;
                        data_out  <= {2'b11, {RW{1'b0}}};
                        prev      <= '0;
                        run       <= '0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_delta_rle_enc_mc.sv
// Directed bench for delta_rle_enc_mc with MAXRUN=4 so run saturation is reachable.
module tb_delta_rle_enc_mc;
    localparam int PIXW = 10;
    localparam int CH   = 3;
    localparam int BUSW = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid_in = 1'b0;
    logic [CH*PIXW-1:0]  px_in = '0;
    logic                eol_in = 1'b0;
    logic                ready_in;
    logic                valid_out;
    logic [BUSW-1:0]     data_out;
    logic                ready_out = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [BUSW-1:0] tq[$];

    delta_rle_enc_mc #(.PIXW(PIXW), .CH(CH), .BUSW(BUSW), .DW(4), .MAXRUN(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .px_in(px_in), .eol_in(eol_in),
        .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && valid_out && ready_out)
            tq.push_back(data_out);

    function automatic logic [CH*PIXW-1:0] pk(input int a, input int b, input int c);
        return {PIXW'(a), PIXW'(b), PIXW'(c)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_px(input logic [CH*PIXW-1:0] p, input logic e);
        int n = 0;
        @(posedge clk); #1;
        valid_in = 1'b1; px_in = p; eol_in = e;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) chk("accept_timeout", 32'(ready_in), 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; eol_in = 1'b0;
    endtask

    task automatic expect_tok(input string tag, input logic [BUSW-1:0] exp);
        int n = 0;
        logic [31:0] obs;
        while (tq.size() == 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        obs = (tq.size() != 0) ? 32'(tq.pop_front()) : 32'hFFFF_FFFF;
        chk(tag, obs, 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_in", 32'(ready_in), 32'd1);

        // run of 3 then small positive delta
        repeat (3) send_px(pk(0, 0, 0), 1'b0);
        send_px(pk(2, 0, 1), 1'b0);
        expect_tok("run3", 16'h8003);
        expect_tok("delta_pos", 16'h0201);

        send_px(pk(1, 0, 1), 1'b0);
        expect_tok("delta_neg", 16'h0F00);

        // literal fallback; ready_in low for exactly two cycles
        send_px(pk(100, 0, 1), 1'b0);
        @(negedge clk); chk("lit_busy0", 32'(ready_in), 32'd0);
        @(negedge clk); chk("lit_busy1", 32'(ready_in), 32'd0);
        @(negedge clk); chk("lit_free", 32'(ready_in), 32'd1);
        expect_tok("lit_c0", 16'h4064);
        expect_tok("lit_c1", 16'h4000);
        expect_tok("lit_c2", 16'h4001);

        send_px(pk(1, 0, 1), 1'b0);
        expect_tok("lit_b0", 16'h4001);
        expect_tok("lit_b1", 16'h4000);
        expect_tok("lit_b2", 16'h4001);

        // matching pixel with EOL, then predictor restarts at zero
        send_px(pk(1, 0, 1), 1'b1);
        expect_tok("eol_run", 16'h8001);
        expect_tok("eol_tok", 16'hC000);

        // 9 zeros with MAXRUN=4, then (5,5,5)
        repeat (9) send_px(pk(0, 0, 0), 1'b0);
        send_px(pk(5, 5, 5), 1'b0);
        expect_tok("sat0", 16'h8004);
        expect_tok("sat1", 16'h8004);
        expect_tok("sat_rem", 16'h8001);
        expect_tok("delta5", 16'h0555);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_valid_out", 32'(valid_out), 32'd0);
        chk("idle_data_hold", 32'(data_out), 32'h0555);

        // backpressure during a literal sequence
        send_px(pk(20, 20, 20), 1'b0);
        ready_out = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(valid_out), 32'd1);
            chk("bp_data", 32'(data_out), 32'h4014);
            chk("bp_ready_in", 32'(ready_in), 32'd0);
        end
        @(posedge clk); #1 ready_out = 1'b1;
        expect_tok("bp_l0", 16'h4014);
        expect_tok("bp_l1", 16'h4014);
        expect_tok("bp_l2", 16'h4014);
        repeat (4) @(posedge clk);
        chk("bp_no_dup", 32'(tq.size()), 32'd0);

        // reset in the middle of a literal sequence
        send_px(pk(200, 0, 0), 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_ready", 32'(ready_in), 32'd1);
        expect_tok("mid_rst_l0", 16'h40C8);
        chk("mid_rst_discard", 32'(tq.size()), 32'd0);
        send_px(pk(0, 0, 0), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_tok", 32'(tq.size()), 32'd0);
        chk("post_rst_quiet", 32'(valid_out), 32'd0);
        send_px(pk(3, 0, 0), 1'b0);
        expect_tok("post_rst_run", 16'h8001);
        expect_tok("post_rst_delta", 16'h0300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
